// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty-cycle ramp controller: arbitrates button and host retarget requests and walks
// the live PWM duty one count toward the target, committing changes only on period starts.
module pwm_duty_ramp_ctrl #(
    parameter int DUTY_W     = 4,
    parameter int MAX_DUTY   = 10,
    parameter int RESET_DUTY = 5,
    parameter int DIV_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_pulse,
    input  logic              dec_pulse,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [DUTY_W-1:0] host_duty,
    input  logic [DIV_W-1:0]  ramp_div,
    input  logic              period_start,
    output logic [DUTY_W-1:0] duty_out,
    output logic [DUTY_W-1:0] target_out,
    output logic              busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RAMP = 1'b1;

    localparam logic [DUTY_W-1:0] L_MAX   = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W-1:0] L_RESET = DUTY_W'(RESET_DUTY);

    logic [0:0]        r_state;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] r_target;
    logic [DIV_W-1:0]  r_int_cnt;

    logic              w_host_acc;
    logic              w_inc;
    logic              w_dec;
    logic [DUTY_W-1:0] w_host_sat;
    logic [DUTY_W-1:0] w_target_next;
    logic              w_ramp_tick;
    logic              w_step;
    logic [DUTY_W-1:0] w_duty_next;
    logic [DIV_W-1:0]  w_cnt_next;
    logic [0:0]        w_state_next;

    assign host_ready = (r_state == ST_IDLE) & ~rst;
    assign w_host_acc = host_valid & host_ready;

    // Simultaneous inc and dec cancel each other out.
    assign w_inc      = inc_pulse & ~dec_pulse;
    assign w_dec      = dec_pulse & ~inc_pulse;
    assign w_host_sat = (host_duty > L_MAX) ? L_MAX : host_duty;

    // Host accept outranks buttons; a losing button pulse is simply dropped.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        w_target_next = r_target;
        if (w_host_acc) begin
            w_target_next = w_host_sat;
        end else if (w_inc && (r_target != L_MAX)) begin
            w_target_next = r_target + 1'b1;
        end else if (w_dec && (r_target != '0)) begin
            w_target_next = r_target - 1'b1;
        end
    end

    assign w_ramp_tick = (r_state == ST_RAMP) & period_start;
    assign w_step      = w_ramp_tick & (r_int_cnt >= ramp_div);

    // The step direction uses the target held before this edge's request.
    always_comb begin
        w_duty_next = r_duty;
        if (w_step) begin
            if (r_target > r_duty) begin
                w_duty_next = r_duty + 1'b1;
            end else begin
                w_duty_next = r_duty - 1'b1;
            end
        end
    end

    always_comb begin
        w_cnt_next = r_int_cnt;
        if (r_state == ST_IDLE || w_step) begin
            w_cnt_next = '0;
        end else if (w_ramp_tick) begin
            w_cnt_next = r_int_cnt + 1'b1;
        end
    end

    assign w_state_next = (w_duty_next != w_target_next) ? ST_RAMP : ST_IDLE;

    // NOTE: reset is sampled on the clock edge, and all state uses non-blocking assignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_duty    <= L_RESET;
            r_target  <= L_RESET;
            r_int_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_duty    <= w_duty_next;
            r_target  <= w_target_next;
            r_int_cnt <= w_cnt_next;
        end
    end

    assign duty_out   = r_duty;
    assign target_out = r_target;
    assign busy       = (r_state == ST_RAMP);

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Self-checking bench for pwm_duty_ramp_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_pwm_duty_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inc_pulse = 1'b0;
    logic       dec_pulse = 1'b0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic [3:0] host_duty = 4'd0;
    logic [7:0] ramp_div = 8'd1;
    logic       period_start = 1'b0;
    logic [3:0] duty_out;
    logic [3:0] target_out;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    pwm_duty_ramp_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .inc_pulse    (inc_pulse),
        .dec_pulse    (dec_pulse),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_duty    (host_duty),
        .ramp_div     (ramp_div),
        .period_start (period_start),
        .duty_out     (duty_out),
        .target_out   (target_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a ramp is pending whenever duty differs from target; each
    // period start while pending counts one period, and after ramp_div+1 counted
    // periods the duty moves one count toward the target held before the edge.
    typedef struct {
        int duty;
        int target;
        int periods;
    } model_t;

    function automatic model_t model_step(model_t c, logic r, logic hv, logic [3:0] hd,
                                          logic inc, logic dec, logic ps, logic [7:0] div);
        model_t n = c;
        if (r) begin
            n.duty    = 5;
            n.target  = 5;
            n.periods = 0;
            return n;
        end
        if (c.duty == c.target) begin
            n.periods = 0;
        end else if (ps) begin
            if (c.periods + 1 >= int'(div) + 1) begin
                n.duty    = (c.target > c.duty) ? c.duty + 1 : c.duty - 1;
                n.periods = 0;
            end else begin
                n.periods = c.periods + 1;
            end
        end
        if (hv && (c.duty == c.target)) begin
            n.target = (int'(hd) > 10) ? 10 : int'(hd);
        end else if (inc && !dec) begin
            n.target = (c.target >= 10) ? 10 : c.target + 1;
        end else if (dec && !inc) begin
            n.target = (c.target <= 0) ? 0 : c.target - 1;
        end
        return n;
    endfunction

    model_t m;
    logic   m_started = 1'b0;
    logic   last_ps   = 1'b0;
    logic   last_rst  = 1'b1;
    int     prev_duty = 0;

    always @(posedge clk) begin
        m         <= model_step(m, rst, host_valid, host_duty, inc_pulse, dec_pulse,
                                period_start, ramp_div);
        last_ps   <= period_start;
        last_rst  <= rst;
        m_started <= 1'b1;
    end

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            check("duty_out",   int'(duty_out),   m.duty);
            check("target_out", int'(target_out), m.target);
            check("busy",       int'(busy),       int'(m.duty != m.target));
            check("host_ready", int'(host_ready), int'((m.duty == m.target) && !rst));
            check("duty_range", int'(duty_out <= 4'd10), 1);
            if (!last_rst && (int'(duty_out) != prev_duty)) begin
                check("duty_change_on_ps", int'(last_ps), 1);
                check("duty_change_size",
                      (int'(duty_out) > prev_duty) ? int'(duty_out) - prev_duty
                                                   : prev_duty - int'(duty_out), 1);
            end
        end
        prev_duty <= int'(duty_out);
    end

    // period_start source: fixed every 10 clocks, or random in the soak phase.
    logic ps_random = 1'b0;
    int   ps_ctr    = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (ps_random) begin
                period_start = ($urandom_range(3) == 0);
            end else begin
                ps_ctr       = (ps_ctr + 1) % 10;
                period_start = (ps_ctr == 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ps(input int k);
        int seen = 0;
        int cyc  = 0;
        while (seen < k && cyc < 200) begin
            @(posedge clk);
            cyc++;
            if (period_start && !rst) seen++;
        end
        #6;
        check("ps_wait", seen, k);
    endtask

    task automatic wait_idle(input int budget);
        int cyc = 0;
        while (busy && cyc < budget) begin
            @(posedge clk);
            #6;
            cyc++;
        end
        check("idle_wait", int'(busy), 0);
    endtask

    initial begin
        int r;
        int cyc;

        // Reset with requests active: nothing may be accepted.
        host_valid = 1'b1;
        host_duty  = 4'd9;
        inc_pulse  = 1'b1;
        tick();
        #4 check("rst_ready0", int'(host_ready), 0);
        inc_pulse = 1'b0;
        dec_pulse = 1'b1;
        tick();
        #4 check("rst_ready1", int'(host_ready), 0);
        check("rst_duty", int'(duty_out), 5);
        rst        = 1'b0;
        host_valid = 1'b0;
        dec_pulse  = 1'b0;
        #4 check("post_rst_ready", int'(host_ready), 1);
        check("post_rst_target", int'(target_out), 5);
        check("post_rst_busy", int'(busy), 0);

        // Host ramp up, ramp_div = 1.
        tick();
        host_valid = 1'b1;
        host_duty  = 4'd8;
        tick();
        host_valid = 1'b0;
        #4 check("up_target", int'(target_out), 8);
        check("up_ready", int'(host_ready), 0);
        check("up_busy", int'(busy), 1);
        wait_ps(2);
        check("up_duty6", int'(duty_out), 6);
        wait_ps(2);
        check("up_duty7", int'(duty_out), 7);
        wait_ps(2);
        check("up_duty8", int'(duty_out), 8);
        check("up_busy_done", int'(busy), 0);
        check("up_ready_back", int'(host_ready), 1);

        // Saturation at both ends.
        tick();
        host_valid = 1'b1;
        host_duty  = 4'd15;
        tick();
        host_valid = 1'b0;
        #4 check("sat_host", int'(target_out), 10);
        inc_pulse = 1'b1;
        repeat (3) tick();
        inc_pulse = 1'b0;
        #4 check("sat_inc", int'(target_out), 10);
        ramp_div  = 8'd0;
        dec_pulse = 1'b1;
        repeat (11) tick();
        dec_pulse = 1'b0;
        #4 check("sat_dec", int'(target_out), 0);
        wait_idle(400);
        check("sat_duty0", int'(duty_out), 0);

        // Mid-ramp retarget with ramp_div = 0.
        tick();
        host_valid = 1'b1;
        host_duty  = 4'd5;
        tick();
        host_valid = 1'b0;
        wait_idle(400);
        tick();
        host_valid = 1'b1;
        host_duty  = 4'd9;
        tick();
        host_valid = 1'b0;
        cyc = 0;
        while (duty_out != 4'd7 && cyc < 10) begin
            wait_ps(1);
            cyc++;
        end
        check("mid_duty7", int'(duty_out), 7);
        dec_pulse = 1'b1;
        repeat (4) tick();
        dec_pulse = 1'b0;
        #4 check("mid_target5", int'(target_out), 5);
        wait_ps(1);
        check("mid_duty6", int'(duty_out), 6);
        wait_ps(1);
        check("mid_duty5", int'(duty_out), 5);
        check("mid_busy", int'(busy), 0);

        // Conflicts.
        tick();
        inc_pulse = 1'b1;
        dec_pulse = 1'b1;
        tick();
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
        #4 check("both_pulses", int'(target_out), 5);
        tick();
        host_valid = 1'b1;
        host_duty  = 4'd2;
        inc_pulse  = 1'b1;
        tick();
        inc_pulse  = 1'b0;
        host_duty  = 4'd7;
        #4 check("host_beats_inc", int'(target_out), 2);
        tick();
        #4 check("held_not_accepted", int'(target_out), 2);
        cyc = 0;
        while (!host_ready && cyc < 400) begin
            tick();
            cyc++;
        end
        check("held_ready", int'(host_ready), 1);
        tick();
        host_valid = 1'b0;
        #4 check("held_loaded", int'(target_out), 7);
        repeat (3) tick();
        #4 check("held_once", int'(target_out), 7);
        wait_idle(400);

        // Randomized soak.
        ps_random = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic rdy;
            rdy = host_ready;
            if (i % 50 == 0) ramp_div = 8'($urandom_range(3));
            r          = $urandom_range(23);
            inc_pulse  = (r == 0) || (r == 2);
            dec_pulse  = (r == 1) || (r == 2);
            host_duty  = 4'($urandom_range(15));
            host_valid = rdy && (r >= 18);
            rst        = (r == 3) && ($urandom_range(15) == 0);
            tick();
        end
        inc_pulse  = 1'b0;
        dec_pulse  = 1'b0;
        host_valid = 1'b0;
        rst        = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
